// File: rtl/leaky_relu_parent_pkg.sv
// Shared Q8.8 fixed-point definitions for the bias, systolic and activation stages.
// Width defaults, the round-half-up constant and the saturation limits live here.
package leaky_relu_parent_pkg;

   localparam int LR_DATA_W = 16;
   localparam int LR_FRAC_W = 8;
   localparam int LR_ROWS   = 2;

   typedef logic signed [LR_DATA_W-1:0]   q_t;
   typedef logic signed [2*LR_DATA_W-1:0] q_prod_t;

   localparam q_prod_t Q_ROUND = q_prod_t'(1) <<< (LR_FRAC_W - 1);
   localparam q_t      Q_MAX   = q_t'(16'sh7FFF);
   localparam q_t      Q_MIN   = q_t'(16'sh8000);

endpackage

// File: rtl/leaky_relu_child.sv
// One column of the leaky-ReLU stage: multiply/round/saturate datapath, 1-cycle
// output register, and the per-batch sample counter.
module leaky_relu_child
   import leaky_relu_parent_pkg::*;
#(
   parameter int DATA_W = LR_DATA_W,
   parameter int FRAC_W = LR_FRAC_W,
   parameter int ROWS   = LR_ROWS
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] alpha,
   input  logic [DATA_W-1:0] data_in,
   input  logic              valid_in,
   input  logic              clear,
   output logic [DATA_W-1:0] data_out,
   output logic              valid_out,
   output logic              full
);

   localparam int PW    = 2 * DATA_W;
   localparam int CNT_W = $clog2(ROWS + 1);

   localparam logic signed [PW-1:0] RND     = PW'(1) <<< (FRAC_W - 1);
   localparam logic signed [PW-1:0] SAT_MAX = (PW'(1) <<< (DATA_W - 1)) - PW'(1);
   localparam logic signed [PW-1:0] SAT_MIN = -SAT_MAX - PW'(1);

   logic signed [PW-1:0] prod;
   logic signed [PW-1:0] scaled;
   logic [DATA_W-1:0]    h;
   logic [CNT_W-1:0]     cnt;

   // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
   always_comb begin
      prod   = PW'($signed(data_in)) * PW'($signed(alpha));
      scaled = (prod + RND) >>> FRAC_W;
      h      = data_in;
      if (data_in[DATA_W-1]) begin
         if (scaled > SAT_MAX)      h = SAT_MAX[DATA_W-1:0];
         else if (scaled < SAT_MIN) h = SAT_MIN[DATA_W-1:0];
         else                       h = scaled[DATA_W-1:0];
      end
   end

   assign full = (cnt == CNT_W'(ROWS));

   // NOTE: state registers use non-blocking assignments so all flops sample the pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_out  <= '0;
         valid_out <= 1'b0;
         cnt       <= '0;
      end else begin
         valid_out <= valid_in;
         if (valid_in) data_out <= h;
         // A valid landing in the clearing cycle is the first sample of the next batch.
         if (clear)                 cnt <= valid_in ? CNT_W'(1) : '0;
         else if (valid_in && !full) cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/leaky_relu_parent.sv
// Leaky-ReLU activation stage: runtime alpha register, two column datapaths and the
// batch-complete pulse that lets the controller advance the layer.
module leaky_relu_parent
   import leaky_relu_parent_pkg::*;
#(
   parameter int DATA_W = LR_DATA_W,
   parameter int FRAC_W = LR_FRAC_W,
   parameter int ROWS   = LR_ROWS
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] lr_leak_factor_in,
   input  logic              lr_leak_load_in,
   input  logic [DATA_W-1:0] lr_data_in_1,
   input  logic              lr_valid_in_1,
   input  logic [DATA_W-1:0] lr_data_in_2,
   input  logic              lr_valid_in_2,
   output logic [DATA_W-1:0] lr_data_out_1,
   output logic              lr_valid_out_1,
   output logic [DATA_W-1:0] lr_data_out_2,
   output logic              lr_valid_out_2,
   output logic              lr_done_out
);

   logic [DATA_W-1:0] alpha;
   logic              full_1;
   logic              full_2;
   logic              clear;

   assign clear = full_1 && full_2;

   // Samples accepted on a load edge still see the old alpha.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         alpha       <= '0;
         lr_done_out <= 1'b0;
      end else begin
         if (lr_leak_load_in) alpha <= lr_leak_factor_in;
         lr_done_out <= clear;
      end
   end

   leaky_relu_child #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .ROWS(ROWS)) u_col_1 (
      .clk       (clk),
      .rst       (rst),
      .alpha     (alpha),
      .data_in   (lr_data_in_1),
      .valid_in  (lr_valid_in_1),
      .clear     (clear),
      .data_out  (lr_data_out_1),
      .valid_out (lr_valid_out_1),
      .full      (full_1)
   );

   leaky_relu_child #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .ROWS(ROWS)) u_col_2 (
      .clk       (clk),
      .rst       (rst),
      .alpha     (alpha),
      .data_in   (lr_data_in_2),
      .valid_in  (lr_valid_in_2),
      .clear     (clear),
      .data_out  (lr_data_out_2),
      .valid_out (lr_valid_out_2),
      .full      (full_2)
   );

endmodule
